// File: rtl/sequential_divider_pkg.sv
// Shared definitions for the divider slice: FSM encoding and default operand widths
// (the multiplier bench uses the same widths).
package sequential_divider_pkg;

  localparam int unsigned DEF_XW = 10;
  localparam int unsigned DEF_YW = 5;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    DONE = 2'd2
  } state_t;

endpackage

// File: rtl/sequential_divider_div_step.sv
// One restoring-division step: shift in the next dividend bit, subtract the divisor
// when the partial remainder reaches it.
module div_step #(
  parameter int unsigned YW = 5
) (
  input  logic [YW:0]   part_i,
  input  logic          bit_i,
  input  logic [YW-1:0] div_i,
  output logic [YW:0]   part_o,
  output logic          qbit_o
);

  logic [YW+1:0] shifted;
  logic [YW+1:0] divisor;

  always_comb begin
    shifted = {part_i, bit_i};
    divisor = {2'b00, div_i};
    qbit_o  = (shifted >= divisor);
    part_o  = qbit_o ? (YW+1)'(shifted - divisor) : (YW+1)'(shifted);
  end

endmodule

// File: rtl/sequential_divider.sv
// Multi-cycle unsigned restoring divider: one quotient bit per clock, MSB first,
// with a one-cycle divide-by-zero shortcut.
module sequential_divider
  import sequential_divider_pkg::*;
#(
  parameter int unsigned XW = DEF_XW,
  parameter int unsigned YW = DEF_YW
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          start,
  input  logic [XW-1:0] x,
  input  logic [YW-1:0] y,
  output logic          busy,
  output logic          done,
  output logic [XW-1:0] q,
  output logic [YW-1:0] r,
  output logic          dz
);

  localparam int unsigned CW = (XW > 1) ? $clog2(XW) : 1;
  localparam logic [CW-1:0] LAST = CW'(XW - 1);

  state_t        state_q, state_d;
  logic [XW-1:0] xs_q, xs_d;
  logic [YW-1:0] y_q, y_d;
  logic [YW:0]   part_q, part_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [XW-1:0] q_q, q_d;
  logic [YW-1:0] r_q, r_d;
  logic          dz_q, dz_d;

  logic [YW:0]   step_part;
  logic          step_qbit;

  div_step #(.YW(YW)) u_step (
    .part_i (part_q),
    .bit_i  (xs_q[XW-1]),
    .div_i  (y_q),
    .part_o (step_part),
    .qbit_o (step_qbit)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_q <= IDLE;
    else     state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (start) state_d = (y == '0) ? DONE : CALC;
      CALC:    if (cnt_q == LAST) state_d = DONE;
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    busy = (state_q == CALC);
    done = (state_q == DONE);
  end

  // The dividend register doubles as the quotient shift register; q/r/dz are
  // separate so they hold steady while the next division runs.
  always_comb begin
    xs_d   = xs_q;
    y_d    = y_q;
    part_d = part_q;
    cnt_d  = cnt_q;
    q_d    = q_q;
    r_d    = r_q;
    dz_d   = dz_q;
    case (state_q)
      IDLE: begin
        if (start) begin
          xs_d   = x;
          y_d    = y;
          part_d = '0;
          cnt_d  = '0;
          if (y == '0) begin
            q_d  = '1;
            r_d  = '0;
            dz_d = 1'b1;
          end
        end
      end
      CALC: begin
        xs_d   = {xs_q[XW-2:0], step_qbit};
        part_d = step_part;
        cnt_d  = cnt_q + 1'b1;
        if (cnt_q == LAST) begin
          q_d  = {xs_q[XW-2:0], step_qbit};
          r_d  = step_part[YW-1:0];
          dz_d = 1'b0;
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      xs_q   <= '0;
      y_q    <= '0;
      part_q <= '0;
      cnt_q  <= '0;
      q_q    <= '0;
      r_q    <= '0;
      dz_q   <= 1'b0;
    end else begin
      xs_q   <= xs_d;
      y_q    <= y_d;
      part_q <= part_d;
      cnt_q  <= cnt_d;
      q_q    <= q_d;
      r_q    <= r_d;
      dz_q   <= dz_d;
    end
  end

  assign q  = q_q;
  assign r  = r_q;
  assign dz = dz_q;

endmodule

// File: doc/sequential_divider.md
SEQUENTIAL_DIVIDER -- requirements
Module: sequential_divider

Interface
REQ-001 SHALL have parameter XW, default 10: dividend and quotient width (matches 5x5 multiplier product width).
REQ-002 SHALL have parameter YW, default 5: divisor and remainder width.
REQ-003 SHALL have port clk, input, 1: single clock, all state updates on rising edge.
REQ-004 SHALL have port rst, input, 1: asynchronous, active-high reset.
REQ-005 SHALL have port start, input, 1: request a division; sampled only in IDLE.
REQ-006 SHALL have port x, input, XW: unsigned dividend, captured on the accepting edge.
REQ-007 SHALL have port y, input, YW: unsigned divisor, captured on the accepting edge.
REQ-008 SHALL have port busy, output, 1: high while a division is in progress (CALC).
REQ-009 SHALL have port done, output, 1: one-cycle pulse when q/r/dz are valid.
REQ-010 SHALL have port q, output, XW: quotient.
REQ-011 SHALL have port r, output, YW: remainder.
REQ-012 SHALL have port dz, output, 1: divide-by-zero flag for the current result.

Function
REQ-013 SHALL implement FSM states IDLE, CALC, DONE.
REQ-014 IDLE with start=1 on a clock edge SHALL capture x and y, clear the partial remainder (YW+1 bits) and the bit counter, and go to CALC if y!=0, else to DONE.
REQ-015 CALC SHALL perform one restoring step per cycle, MSB first: shift the next dividend bit into the partial remainder; if partial >= y, subtract y and shift quotient bit 1, else shift 0.
REQ-016 CALC SHALL run exactly XW cycles, counter 0..XW-1, then go to DONE.
REQ-017 DONE SHALL assert done for exactly one cycle and return to IDLE unconditionally.
REQ-018 Latency SHALL be XW+1 cycles from the accepting edge to done high (11 at defaults); divide-by-zero SHALL take 1 cycle.
REQ-019 On y==0, results SHALL be q = all ones, r = 0, dz = 1; otherwise dz = 0.
REQ-020 Results SHALL satisfy x == q*y + r with r < y, for all y != 0.
REQ-021 q, r, dz SHALL hold their last values from done until the next accepted start.
REQ-022 start during CALC or DONE SHALL be ignored, with no queuing.
REQ-023 start held high continuously SHALL begin a new division on the first IDLE cycle after DONE.
REQ-024 Changes on x or y after the accepting edge SHALL NOT affect the running division.

Reset
REQ-025 rst=1 SHALL immediately force state IDLE, busy=0, done=0, q=0, r=0, dz=0, and clear the counter and internal registers.
REQ-026 rst asserted mid-CALC SHALL abort the division, with no done pulse generated.
REQ-027 After rst deasserts, the first start SHALL be accepted on the next rising edge.

Structure
REQ-028 Shared package SHALL hold the state encoding (IDLE, CALC, DONE) and the default XW/YW constants, so the multiplier and divider benches share widths.
REQ-029 The single restoring step SHALL be a combinational sub-module div_step (inputs: partial remainder, next bit, divisor; outputs: new partial remainder, quotient bit).
REQ-030 The top level SHALL contain only the FSM, counter, and registers.

Verification
REQ-031 x=1000, y=31, start pulse -> done 11 cycles later, q=32, r=8, dz=0; busy high for 10 cycles.
REQ-032 x=1023, y=1 -> q=1023, r=0; x=5, y=7 -> q=0, r=5; x=0, y=31 -> q=0, r=0.
REQ-033 x=77, y=0 -> done 1 cycle after accept, dz=1, q=10'h3FF, r=0, busy never high.
REQ-034 start re-pulsed mid-CALC with different x/y -> ignored; first result unchanged (e.g. 1000/31 still gives 32 r 8).
REQ-035 rst pulsed at CALC cycle 5 -> outputs zero at once, no done pulse; a following 100/9 gives q=11, r=1.
REQ-036 Random sweep, 200 operand pairs -> check q*y+r==x and r<y, compared against a behavioural reference model.
